// File: rtl/vc_push_cond.sv
// vc_push_cond: write-side controller for the two virtual-channel FIFOs.
// A one-entry hold stage takes packets from a valid/ready stream. The class
// bit (MSB) of each packet selects VC0 or VC1. The held packet is pushed into
// its channel when that channel has room. The block keeps an occupancy count
// per channel from its own writes and the reader's pops, and decodes from
// those counts the empty, full and almost-full flags that the pop side uses.
module vc_push_cond #(
    parameter int DATA_W    = 6,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              VC0_wr,
    output logic              VC1_wr,
    output logic [DATA_W-1:0] vc_data,
    input  logic              VC0_rd,
    input  logic              VC1_rd,
    output logic              VC0_empty,
    output logic              VC1_empty,
    output logic              VC0_full,
    output logic              VC1_full,
    output logic              VC0_almost_full,
    output logic              VC1_almost_full,
    output logic [CNT_W-1:0]  VC0_count,
    output logic [CNT_W-1:0]  VC1_count,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,  // nothing held
        ST_LOADED  = 2'd1,  // packet held, target channel has room
        ST_BLOCKED = 2'd2   // packet held, target channel full
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_data_q;
    logic [CNT_W-1:0]  vc0_cnt_q, vc0_cnt_d;
    logic [CNT_W-1:0]  vc1_cnt_q, vc1_cnt_d;
    logic              err_q;

    logic hold_valid;
    logic hold_cls;
    logic new_cls;
    logic vc0_full_q, vc1_full_q;
    logic push;
    logic accept;
    logic rd_eff0, rd_eff1;

    assign hold_valid = (state_q != ST_EMPTY);
    assign hold_cls   = hold_data_q[DATA_W-1];
    assign new_cls    = in_data[DATA_W-1];

    // A write decision depends only on the registered count. A pop arriving
    // in the same cycle does not unblock the write until the next cycle.
    assign vc0_full_q = (vc0_cnt_q == DEPTH_C);
    assign vc1_full_q = (vc1_cnt_q == DEPTH_C);

    // A pop on an empty channel is ignored so that the counters never wrap.
    assign rd_eff0 = VC0_rd && (vc0_cnt_q != '0);
    assign rd_eff1 = VC1_rd && (vc1_cnt_q != '0);

    // Output decode: push strobes, upstream ready and accept.
    always_comb begin
        // NOTE: give every signal assigned in always_comb a default first so
        // that no path leaves it unassigned and no latch is inferred.
        push     = 1'b0;
        VC0_wr   = 1'b0;
        VC1_wr   = 1'b0;
        in_ready = 1'b1;
        if (hold_valid) begin
            push     = hold_cls ? !vc1_full_q : !vc0_full_q;
            VC0_wr   = push && !hold_cls;
            VC1_wr   = push &&  hold_cls;
            in_ready = push;
        end
        accept = in_valid && in_ready;
    end

    // Next occupancy: add this block's write, subtract the reader's valid pop.
    always_comb begin
        vc0_cnt_d = vc0_cnt_q + CNT_W'(VC0_wr) - CNT_W'(rd_eff0);
        vc1_cnt_d = vc1_cnt_q + CNT_W'(VC1_wr) - CNT_W'(rd_eff1);
    end

    // Next state: classify the packet held next cycle against its channel's next count.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (new_cls ? (vc1_cnt_d == DEPTH_C) : (vc0_cnt_d == DEPTH_C))
                state_d = ST_BLOCKED;
            else
                state_d = ST_LOADED;
        end else if (push) begin
            state_d = ST_EMPTY;
        end else if (hold_valid) begin
            if (hold_cls ? (vc1_cnt_d == DEPTH_C) : (vc0_cnt_d == DEPTH_C))
                state_d = ST_BLOCKED;
            else
                state_d = ST_LOADED;
        end
    end

    // State, hold register, counters and sticky underflow flag.
    always_ff @(posedge clk or negedge reset_L) begin
        // NOTE: sequential state uses non-blocking (<=) assignments so that
        // every register samples values from before the edge, whatever order
        // the statements appear in.
        if (!reset_L) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            vc0_cnt_q   <= '0;
            vc1_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            vc0_cnt_q <= vc0_cnt_d;
            vc1_cnt_q <= vc1_cnt_d;
            if (accept)
                hold_data_q <= in_data;
            if ((VC0_rd && vc0_cnt_q == '0) || (VC1_rd && vc1_cnt_q == '0))
                err_q <= 1'b1;
        end
    end

    assign vc_data         = hold_data_q;
    assign VC0_count       = vc0_cnt_q;
    assign VC1_count       = vc1_cnt_q;
    assign VC0_empty       = (vc0_cnt_q == '0);
    assign VC1_empty       = (vc1_cnt_q == '0);
    assign VC0_full        = vc0_full_q;
    assign VC1_full        = vc1_full_q;
    assign VC0_almost_full = (vc0_cnt_q >= AF_C);
    assign VC1_almost_full = (vc1_cnt_q >= AF_C);
    assign err_underflow   = err_q;

endmodule
